// File: rtl/command_reader_pkg.sv
// Shared constants for the command-reader control FSM and its datapath:
// opcodes, datapath select codes, FSM state encoding and the opcode decoder.
package command_reader_pkg;

    // Opcode field patterns, matched against the top bits of Command
    localparam logic [7:0] OPC_PING     = 8'h00;
    localparam logic [3:0] OPC_SET_FREQ = 4'b0010;
    localparam logic [3:0] OPC_ARM      = 4'b0011;
    localparam logic [4:0] OPC_READ_MAX = 5'b00010;

    localparam logic [1:0] WSEL_HOLD  = 2'b00;
    localparam logic [1:0] WSEL_MAX   = 2'b01;
    localparam logic [1:0] WSEL_TRUE  = 2'b10;
    localparam logic [1:0] WSEL_FALSE = 2'b11;

    localparam logic [1:0] TSEL_CLEAR = 2'b00;
    localparam logic [1:0] TSEL_COUNT = 2'b01;

    typedef enum logic [2:0] {
        OP_SET_THR,
        OP_SET_FREQ,
        OP_READ_MAX,
        OP_ARM,
        OP_PING,
        OP_UNDEF
    } op_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DECODE,
        ST_SET,
        ST_MAX_WAIT,
        ST_LOAD,
        ST_TMR_CLEAR,
        ST_ARMED,
        ST_SEND,
        ST_TX_GAP
    } state_t;

    function automatic op_t decode_op(input logic [7:0] cmd);
        op_t op;
        if (cmd[7])                         op = OP_SET_THR;
        else if (cmd[7:4] == OPC_SET_FREQ)  op = OP_SET_FREQ;
        else if (cmd[7:4] == OPC_ARM)       op = OP_ARM;
        else if (cmd[7:3] == OPC_READ_MAX)  op = OP_READ_MAX;
        else if (cmd == OPC_PING)           op = OP_PING;
        else                                op = OP_UNDEF;
        return op;
    endfunction

endpackage

// File: rtl/command_reader_control.sv
// Control FSM for the command reader: accepts UART command bytes, drives the
// datapath selects, sequences the arm/timeout handshake and issues one reply.
module command_reader_control
    import command_reader_pkg::*;
#(
    parameter int CLEAR_CYCLES = 96,
    parameter int BLANK_CYCLES = 96,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       Rx_Valid,
    input  logic [7:0] Rx_Data,
    input  logic       Trigger,
    input  logic       Timeout,
    input  logic       Tx_Ready,
    output logic [7:0] Command_Q,
    output logic [1:0] Word_To_Send_sel,
    output logic [1:0] Timer_sel,
    output logic       Set_Frequency_sel,
    output logic       Set_Threshold_sel,
    output logic       Tx_Start,
    output logic       Busy,
    output logic       Overrun
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tx_start;

    state_t           w_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_reply;
    logic             w_tx_start_next;
    op_t              w_op;

    assign w_op = decode_op(Command_Q);

    // Outputs are registered from the next-state decode, so each output
    // reflects the state the FSM occupies in that same cycle.
    always_comb begin
        w_next          = r_state;
        w_cnt_next      = r_cnt;
        w_reply         = WSEL_FALSE;
        w_tx_start_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Rx_Valid) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_op)
                    OP_SET_THR, OP_SET_FREQ: w_next = ST_SET;
                    OP_READ_MAX:             w_next = ST_MAX_WAIT;
                    OP_ARM: begin
                        w_next     = ST_TMR_CLEAR;
                        w_cnt_next = CNT_W'(CLEAR_CYCLES - 1);
                    end
                    OP_PING: begin
                        w_next  = ST_LOAD;
                        w_reply = WSEL_TRUE;
                    end
                    default: begin
                        w_next  = ST_LOAD;
                        w_reply = WSEL_FALSE;
                    end
                endcase
            end
            ST_SET: begin
                w_next  = ST_LOAD;
                w_reply = WSEL_TRUE;
            end
            // Extra cycle lets the channel mux settle before Max_Value is loaded
            ST_MAX_WAIT: begin
                w_next  = ST_LOAD;
                w_reply = WSEL_MAX;
            end
            ST_LOAD: w_next = ST_SEND;
            ST_TMR_CLEAR: begin
                if (r_cnt == '0) begin
                    w_next     = ST_ARMED;
                    w_cnt_next = CNT_W'(BLANK_CYCLES - 1);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_ARMED: begin
                if (Trigger) begin
                    w_next  = ST_LOAD;
                    w_reply = WSEL_TRUE;
                end else if (Timeout && r_cnt == '0) begin
                    w_next  = ST_LOAD;
                    w_reply = WSEL_FALSE;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            // Stay one extra cycle in SEND while the Tx_Start pulse is out
            ST_SEND: begin
                if (r_tx_start)    w_next = ST_TX_GAP;
                else if (Tx_Ready) w_tx_start_next = 1'b1;
            end
            ST_TX_GAP: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state           <= ST_IDLE;
            r_cnt             <= '0;
            r_tx_start        <= 1'b0;
            Command_Q         <= 8'h00;
            Word_To_Send_sel  <= WSEL_HOLD;
            Timer_sel         <= TSEL_CLEAR;
            Set_Frequency_sel <= 1'b0;
            Set_Threshold_sel <= 1'b0;
            Busy              <= 1'b0;
            Overrun           <= 1'b0;
        end else begin
            r_state           <= w_next;
            r_cnt             <= w_cnt_next;
            r_tx_start        <= w_tx_start_next;
            if (r_state == ST_IDLE && Rx_Valid) Command_Q <= Rx_Data;
            Word_To_Send_sel  <= (w_next == ST_LOAD) ? w_reply : WSEL_HOLD;
            Timer_sel         <= (w_next == ST_ARMED) ? TSEL_COUNT : TSEL_CLEAR;
            Set_Threshold_sel <= (w_next == ST_SET) && (w_op == OP_SET_THR);
            Set_Frequency_sel <= (w_next == ST_SET) && (w_op == OP_SET_FREQ);
            Busy              <= (w_next != ST_IDLE);
            Overrun           <= Rx_Valid && (r_state != ST_IDLE);
        end
    end

    assign Tx_Start = r_tx_start;

endmodule

// File: tb/tb_command_reader_control.sv
// Directed bench for command_reader_control: one linear sequence of commands
// with hand-computed cycle-exact expectations.
module tb_command_reader_control;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       trigger;
  logic       timeout;
  logic       tx_ready;
  logic [7:0] command_q;
  logic [1:0] word_sel;
  logic [1:0] timer_sel;
  logic       set_freq;
  logic       set_thr;
  logic       tx_start;
  logic       busy;
  logic       overrun;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int b2b = 0;
  int tx0 = 0;
  logic tx_prev = 1'b0;

  always #5 clk = ~clk;

  command_reader_control #(
    .CLEAR_CYCLES(96),
    .BLANK_CYCLES(96),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .Rx_Valid(rx_valid),
    .Rx_Data(rx_data),
    .Trigger(trigger),
    .Timeout(timeout),
    .Tx_Ready(tx_ready),
    .Command_Q(command_q),
    .Word_To_Send_sel(word_sel),
    .Timer_sel(timer_sel),
    .Set_Frequency_sel(set_freq),
    .Set_Threshold_sel(set_thr),
    .Tx_Start(tx_start),
    .Busy(busy),
    .Overrun(overrun)
  );

  always @(negedge clk) begin
    if (tx_start) tx_cnt++;
    if (tx_start && tx_prev) b2b++;
    tx_prev = tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte presented in cycle 0; returns positioned in cycle 1
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    cyc      = 0;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    reset_b  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    trigger  = 1'b0;
    timeout  = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_q", command_q, 8'h00);
    chk("rst_word_sel", word_sel, 2'b00);
    chk("rst_timer_sel", timer_sel, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_set_thr", set_thr, 1'b0);
    chk("rst_set_freq", set_freq, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset_b = 1'b1;
    tick();
    tick();

    // PING
    send_byte(8'h00);
    chk("ping_busy_c1", busy, 1'b1);
    chk("ping_sel_c1", word_sel, 2'b00);
    goto(2);
    chk("ping_sel_c2", word_sel, 2'b10);
    goto(3);
    chk("ping_sel_c3", word_sel, 2'b00);
    chk("ping_tx_c3", tx_start, 1'b0);
    goto(4);
    chk("ping_tx_c4", tx_start, 1'b1);
    goto(5);
    chk("ping_tx_c5", tx_start, 1'b0);
    chk("ping_busy_c5", busy, 1'b1);
    goto(6);
    chk("ping_busy_c6", busy, 1'b0);

    // SET_THR
    send_byte(8'h85);
    chk("thr_c1", set_thr, 1'b0);
    goto(2);
    chk("thr_c2", set_thr, 1'b1);
    chk("thr_freq_c2", set_freq, 1'b0);
    chk("thr_value", command_q[6:0], 7'h05);
    goto(3);
    chk("thr_c3", set_thr, 1'b0);
    chk("thr_sel_c3", word_sel, 2'b10);
    goto(5);
    chk("thr_tx_c5", tx_start, 1'b1);
    goto(7);
    chk("thr_busy_c7", busy, 1'b0);

    // SET_FREQ
    send_byte(8'h2A);
    goto(2);
    chk("freq_c2", set_freq, 1'b1);
    chk("freq_thr_c2", set_thr, 1'b0);
    goto(3);
    chk("freq_c3", set_freq, 1'b0);
    chk("freq_sel_c3", word_sel, 2'b10);
    goto(7);

    // READ_MAX channel 3
    send_byte(8'h13);
    chk("max_chan", command_q[2:0], 3'd3);
    goto(2);
    chk("max_sel_c2", word_sel, 2'b00);
    goto(3);
    chk("max_sel_c3", word_sel, 2'b01);
    goto(4);
    chk("max_tx_c4", tx_start, 1'b0);
    goto(5);
    chk("max_tx_c5", tx_start, 1'b1);
    goto(7);

    // Undefined opcode
    send_byte(8'h1B);
    goto(2);
    chk("undef_sel_c2", word_sel, 2'b11);
    goto(4);
    chk("undef_tx_c4", tx_start, 1'b1);
    goto(6);
    chk("undef_busy_c6", busy, 1'b0);

    // ARM, trigger at cycle 300
    send_byte(8'h30);
    goto(97);
    chk("arm_timer_c97", timer_sel, 2'b00);
    goto(98);
    chk("arm_timer_c98", timer_sel, 2'b01);
    goto(300);
    chk("arm_sel_c300", word_sel, 2'b00);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("arm_trig_sel", word_sel, 2'b10);
    chk("arm_timer_exit", timer_sel, 2'b00);
    goto(303);
    chk("arm_tx_c303", tx_start, 1'b1);
    goto(305);
    chk("arm_busy_c305", busy, 1'b0);

    // ARM, Timeout held through blanking, then Trigger+Timeout together
    send_byte(8'h30);
    goto(98);
    timeout = 1'b1;
    goto(193);
    timeout = 1'b0;
    chk("blank_no_false", word_sel, 2'b00);
    chk("blank_still_armed", timer_sel, 2'b01);
    goto(400);
    trigger = 1'b1;
    timeout = 1'b1;
    tick();
    trigger = 1'b0;
    timeout = 1'b0;
    chk("both_trig_wins", word_sel, 2'b10);
    goto(405);

    // ARM, overrun at cycle 100, timeout at cycle 250
    send_byte(8'h30);
    goto(100);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    chk("overrun_c101", overrun, 1'b1);
    chk("overrun_cmd_q", command_q, 8'h30);
    tick();
    chk("overrun_c102", overrun, 1'b0);
    goto(250);
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    chk("timeout_sel", word_sel, 2'b11);
    goto(255);
    chk("timeout_busy", busy, 1'b0);

    // Tx_Ready low for 50 cycles in SEND
    tx_ready = 1'b0;
    tx0 = tx_cnt;
    send_byte(8'h00);
    goto(52);
    chk("stall_tx_c52", tx_start, 1'b0);
    chk("stall_busy_c52", busy, 1'b1);
    goto(53);
    tx_ready = 1'b1;
    tick();
    chk("stall_tx_c54", tx_start, 1'b1);
    tick();
    chk("stall_tx_c55", tx_start, 1'b0);
    goto(56);
    chk("stall_busy_c56", busy, 1'b0);
    chk("stall_one_tx", tx_cnt - tx0, 1);

    // Reset mid-ARMED
    send_byte(8'h30);
    goto(150);
    reset_b = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_timer", timer_sel, 2'b00);
    chk("midrst_cmd_q", command_q, 8'h00);
    chk("midrst_sel", word_sel, 2'b00);
    tx0 = tx_cnt;
    tick();
    reset_b = 1'b1;
    repeat (350) tick();
    chk("midrst_no_tx", tx_cnt - tx0, 0);
    chk("midrst_idle", busy, 1'b0);

    chk("no_b2b_tx", b2b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/command_reader_control.md
# command_reader_control

Control FSM for the command-reader datapath in the acoustics FPGA. It accepts command bytes from the UART receiver, decodes them, and drives the datapath selects: word select, timer select, frequency load and threshold load. It also sequences the trigger-arm/timeout handshake across the slow-clock timer and issues one reply byte per command to the UART transmitter. It sits between `UART_RX`/`UART_TX` and the command-reader datapath, and all of its outputs are registered.

## Interface
- `CLEAR_CYCLES`, default 96: clk cycles `Timer_sel`=CLEAR is held before counting. Must be ≥ 6 slow_clk periods.
- `BLANK_CYCLES`, default 96: clk cycles after entering ARMED during which `Timeout` is ignored. Covers return-path sync latency.
- `CNT_W`, default 8: width of the internal wait counter. Must hold max(CLEAR_CYCLES, BLANK_CYCLES).

Ports:
- `clk` in 1: system clock (100 MHz domain).
- `reset_b` in 1: asynchronous, active-low reset.
- `Rx_Valid` in 1: one-cycle pulse; `Rx_Data` valid this cycle.
- `Rx_Data` in 8: received command byte.
- `Trigger` in 1: level from the threshold detector, synchronous to clk.
- `Timeout` in 1: timer expiry from the datapath, already synchronized to clk.
- `Tx_Ready` in 1: UART transmitter idle.
- `Command_Q` out 8: registered command; drives the datapath `Command` input.
- `Word_To_Send_sel` out 2: 00 HOLD, 01 MAX_VALUE, 10 TRUE (loads 8'h30), 11 FALSE (loads 8'h31).
- `Timer_sel` out 2: 00 CLEAR, 01 COUNT, 1x reserved.
- `Set_Frequency_sel` out 1: one-cycle load of `Command[3:0]` into frequency.
- `Set_Threshold_sel` out 1: one-cycle load of `Command[6:0]` into threshold.
- `Tx_Start` out 1: one-cycle pulse to send `Word_To_Send`.
- `Busy` out 1: high whenever state ≠ IDLE.
- `Overrun` out 1: one-cycle pulse when `Rx_Valid` arrives while Busy.

## Operation
Opcode decode on `Command_Q`:
- `1xxxxxxx`: SET_THR. Pulse `Set_Threshold_sel`, then reply TRUE.
- `0010xxxx`: SET_FREQ. Pulse `Set_Frequency_sel`, then reply TRUE.
- `00010ccc`: READ_MAX on channel ccc. Reply `Max_Value[9:2]`.
- `0011xxxx`: ARM. Reply TRUE on trigger, FALSE on timeout.
- `00000000`: PING. Reply TRUE.
- Anything else: reply FALSE.

States:
- IDLE: `Timer_sel`=CLEAR. On `Rx_Valid`, `Command_Q`←`Rx_Data` and go to DECODE.
- DECODE: branch by opcode. PING goes to LOAD with TRUE. Undefined opcodes go to LOAD with FALSE.
- SET: assert the matching set-sel for exactly 1 cycle, then go to LOAD with TRUE.
- LOAD: `Word_To_Send_sel` is driven for exactly 1 cycle, then go to SEND. For READ_MAX, LOAD is entered no earlier than 2 cycles after the `Command_Q` update, so the channel mux settles.
- TMR_CLEAR: `Timer_sel`=CLEAR; counter loads CLEAR_CYCLES-1. At 0, go to ARMED and reload the counter with BLANK_CYCLES-1.
- ARMED: `Timer_sel`=COUNT.
  - `Trigger`=1 → LOAD(TRUE).
  - `Timeout`=1 with the counter at 0 → LOAD(FALSE).
  - Both in the same cycle → Trigger wins.
  - `Timeout` during blanking is ignored.
  - On exit, `Timer_sel` returns to CLEAR.
- SEND: wait for `Tx_Ready`=1, then pulse `Tx_Start` and go to TX_GAP.
- TX_GAP: 1 cycle; `Tx_Ready` is not sampled. Then go to IDLE.

General rules:
- `Word_To_Send_sel` is HOLD in every state except LOAD.
- `Rx_Valid` while not IDLE: byte dropped, `Overrun` pulses, `Command_Q` unchanged.

## Timing
- Reset (async, any state): state IDLE, `Command_Q`=0, `Word_To_Send_sel`=00, `Timer_sel`=00, all pulses 0, `Busy`=0. Reset mid-ARMED abandons the command with no reply.
- PING latency: `Rx_Valid` at cycle 0 → DECODE 1 → LOAD 2 → SEND 3. `Tx_Start` at cycle 4 if `Tx_Ready` is held high. `Word_To_Send` is valid from cycle 3.
- SET_*: set-sel asserted at cycle 2. `Tx_Start` at cycle 5.
- READ_MAX: `Tx_Start` at cycle 5.
- ARM: `Timer_sel`=COUNT from cycle 2+CLEAR_CYCLES. Earliest FALSE reply requires at least BLANK_CYCLES in ARMED.
- `Tx_Start` never asserts on two consecutive cycles. There is at most one `Tx_Start` per accepted command.
- Back-to-back commands: next acceptance is no earlier than 1 cycle after `Tx_Start`.

## Structure
- Package `command_reader_pkg` holds:
  - opcode constants;
  - `Word_To_Send_sel` codes (HOLD, MAX_VALUE, TRUE, FALSE);
  - `Timer_sel` codes (CLEAR, COUNT);
  - the state enum.
- The datapath also uses these constants, so they live in the package rather than in this block.
- No sub-module. A single inline down-counter of width `CNT_W` is shared by TMR_CLEAR and ARMED blanking.

## Test plan
- Byte 8'h00 with `Tx_Ready`=1 → `Word_To_Send_sel`=10 at cycle 2; `Tx_Start` single pulse at cycle 4; `Busy` falls at cycle 6.
- Byte 8'h85 → `Set_Threshold_sel` high only at cycle 2 with `Command_Q[6:0]`=7'h05; reply sel=10. Byte 8'h2A → `Set_Frequency_sel` high only at cycle 2.
- Byte 8'h13 → `Command_Q[2:0]`=3; sel=01 at cycle 3; `Tx_Start` at cycle 5. Byte 8'h1B → sel=11 (FALSE).
- Byte 8'h30, `Trigger` at cycle 300 → sel=10. Repeat with `Timeout` forced high throughout blanking, then `Trigger`=`Timeout`=1 simultaneously at cycle 400 → sel=10; no early FALSE.
- ARM with no `Trigger`, `Timeout` at cycle 250 → sel=11. Second `Rx_Valid` at cycle 100 → `Overrun` pulse and `Command_Q` unchanged.
- `Tx_Ready`=0 for 50 cycles in SEND → `Tx_Start` waits until `Tx_Ready`=1. Assert `reset_b`=0 mid-ARMED → all outputs reset immediately and no `Tx_Start` follows.
